// File: rtl/sfr_uart_tx_pkg.sv
// Shared SFR addresses, SCON bit positions and transmitter state encoding.
package sfr_uart_tx_pkg;

  localparam logic [7:0] SFR_SCON = 8'h98;
  localparam logic [7:0] SFR_SBUF = 8'h99;

  localparam int unsigned SCON_TI = 1;
  localparam int unsigned SCON_RI = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick pulses on the last clock of each serial bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_tick = enable && (cnt_q == CntMax);

  // Count clocks within the current bit; wrap at the end of each bit.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= bit_tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sfr_uart_tx.sv
// 8051 serial port transmitter (mode-1 framing) with SCON/SBUF SFR access.
module sfr_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic       bit_in,
  output logic [7:0] rd_data,
  output logic       txd,
  output logic       busy,
  output logic       int_req
);

  import sfr_uart_tx_pkg::*;

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sbuf_q, sbuf_d;
  logic [7:0] scon_q, scon_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       set_ti;
  logic       bit_tick;
  logic       wr_sbuf, wr_scon, wr_scon_b;

  assign wr_sbuf   = wr_en && !wr_bit_en && (addr == SFR_SBUF);
  assign wr_scon   = wr_en && !wr_bit_en && (addr == SFR_SCON);
  assign wr_scon_b = wr_en && wr_bit_en && (addr[7:3] == SFR_SCON[7:3]);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == StIdle),
    .enable  (state_q != StIdle),
    .bit_tick(bit_tick)
  );

  // Frame sequencing: SBUF loads are only accepted from idle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    sbuf_d    = sbuf_q;
    bit_cnt_d = bit_cnt_q;
    set_ti    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_sbuf) begin
          shift_d = data_in;
          sbuf_d  = data_in;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
            set_ti  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // SCON update; the hardware TI set is applied last so it beats a software clear.
  always_comb begin
    scon_d = scon_q;
    if (wr_scon) begin
      scon_d = data_in;
    end
    if (wr_scon_b) begin
      scon_d[addr[2:0]] = bit_in;
    end
    if (set_ti) begin
      scon_d[SCON_TI] = 1'b1;
    end
  end

  // State and SFR registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      sbuf_q    <= 8'h00;
      scon_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      sbuf_q    <= sbuf_d;
      scon_q    <= scon_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Serial line and status outputs decoded from registered state.
  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign int_req = scon_q[SCON_TI] | scon_q[SCON_RI];

  // SFR read mux contribution; zero for addresses outside this block.
  always_comb begin
    rd_data = 8'h00;
    if (addr == SFR_SCON) begin
      rd_data = scon_q;
    end else if (addr == SFR_SBUF) begin
      rd_data = sbuf_q;
    end
  end

endmodule

// File: tb/tb_sfr_uart_tx.sv
// Scoreboard bench: accepted SBUF writes push the expected per-cycle line waveform,
// a negedge monitor pops and compares txd/busy plus SFR read data and int_req.
module tb_sfr_uart_tx;

  localparam int C = 4;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       wr_en;
  logic       wr_bit_en;
  logic       bit_in;
  logic [7:0] rd_data;
  logic       txd;
  logic       busy;
  logic       int_req;

  sfr_uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .addr     (addr),
    .wr_en    (wr_en),
    .wr_bit_en(wr_bit_en),
    .bit_in   (bit_in),
    .rd_data  (rd_data),
    .txd      (txd),
    .busy     (busy),
    .int_req  (int_req)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic txd;
    logic busy;
    logic ti;  // the edge starting this cycle sets TI
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_scon;
  logic [7:0] m_sbuf;
  logic       m_on = 1'b0;
  logic       m_busy_exp = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Reference model: a frame is 10 slots of C cycles (start, 8 data LSB first, stop).
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_scon = 8'h00;
      m_sbuf = 8'h00;
      m_on   = 1'b1;
    end else if (m_on) begin
      logic hw_ti;
      hw_ti = (q.size() > 0) && q[0].ti;
      if (wr_en && !wr_bit_en && addr == 8'h98) m_scon = data_in;
      if (wr_en && wr_bit_en && addr[7:3] == 5'h13) m_scon[addr[2:0]] = bit_in;
      if (hw_ti) m_scon[1] = 1'b1;
      if (wr_en && !wr_bit_en && addr == 8'h99 && !m_busy_exp) begin
        m_sbuf = data_in;
        for (int k = 0; k < 10 * C; k++) begin
          exp_t e;
          e.busy = 1'b1;
          e.ti   = (k == 9 * C);
          if (k < C) e.txd = 1'b0;
          else if (k < 9 * C) e.txd = data_in[(k - C) / C];
          else e.txd = 1'b1;
          q.push_back(e);
        end
      end
    end
  end

  // Monitor: one expected sample per cycle, idle line when nothing is queued.
  always @(negedge clock) begin
    if (m_on) begin
      exp_t       e;
      logic [7:0] exp_rd;
      if (q.size() > 0) e = q.pop_front();
      else e = '{txd: 1'b1, busy: 1'b0, ti: 1'b0};
      m_busy_exp = e.busy;
      check("txd", {7'd0, txd}, {7'd0, e.txd});
      check("busy", {7'd0, busy}, {7'd0, e.busy});
      check("int_req", {7'd0, int_req}, {7'd0, m_scon[1] | m_scon[0]});
      if (addr == 8'h98) exp_rd = m_scon;
      else if (addr == 8'h99) exp_rd = m_sbuf;
      else exp_rd = 8'h00;
      check("rd_data", rd_data, exp_rd);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_idle();
    wr_en     = 1'b0;
    wr_bit_en = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic byte_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1; wr_bit_en = 1'b0;
    step(1);
    bus_idle();
  endtask

  task automatic bit_wr(input logic [7:0] a, input logic b);
    addr = a; bit_in = b; wr_en = 1'b1; wr_bit_en = 1'b1;
    step(1);
    bus_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_in = 8'h00; addr = 8'h00;
    bus_idle();
    step(2);
    reset = 1'b0;
    step(2);

    // Directed A5 frame; write 0x3C mid-frame, bit-clear TI on the hardware set edge.
    byte_wr(8'h99, 8'hA5);      // edge 0
    step(9);
    byte_wr(8'h99, 8'h3C);      // edge 10, ignored
    step(25);
    bit_wr(8'h99, 1'b0);        // edge 36, hardware set wins
    bit_wr(8'h99, 1'b0);        // edge 37, clears TI
    addr = 8'h98;
    step(8);

    // SCON byte then bit write; read an unrelated address.
    byte_wr(8'h98, 8'h41);
    bit_wr(8'h9F, 1'b1);
    addr = 8'h98;
    step(2);
    addr = 8'h50;
    step(2);
    byte_wr(8'h98, 8'h00);

    // Reset in the middle of a frame, then a clean frame.
    byte_wr(8'h99, 8'h5A);      // edge 0
    step(19);
    reset = 1'b1;
    step(1);                    // edge 20
    reset = 1'b0;
    addr = 8'h98;
    step(2);
    byte_wr(8'h99, 8'hC3);
    step(10 * C + 2);

    // SBUF write on the STOP->IDLE edge is dropped; one cycle later it starts.
    byte_wr(8'h99, 8'h81);      // edge 0
    step(10 * C - 1);
    byte_wr(8'h99, 8'h17);      // edge 40, ignored
    byte_wr(8'h99, 8'h29);      // edge 41, accepted
    addr = 8'h99;
    step(10 * C + 2);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0, 1: byte_wr(8'h99, 8'($urandom));
        2: byte_wr(8'h98, 8'($urandom));
        3: bit_wr(8'h98 + 8'($urandom_range(0, 7)), 1'($urandom));
        4: begin
          if ($urandom_range(0, 1) == 0) byte_wr(8'h50, 8'($urandom));
          else bit_wr(8'h20, 1'($urandom));
        end
        default: begin
          int r;
          r = $urandom_range(0, 2);
          addr = (r == 0) ? 8'h98 : (r == 1) ? 8'h99 : 8'($urandom);
          step($urandom_range(1, 45));
        end
      endcase
    end
    addr = 8'h98;
    step(12 * C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfr_uart_tx.md
Name: sfr_uart_tx

Overview:
- 8051 serial-port transmit SFR block, mode 1 (8-bit UART: start bit, 8 data bits LSB first, stop bit).
- Consumes the internal SFR write bus to load the transmit shift register (byte writes to SBUF) and to update SCON (byte writes and single-bit writes).
- Drives TXD, sets SCON.TI in hardware, and returns SCON/SBUF contents on the SFR read path.
- Sits beside the other SFR blocks on the same write bus; its read data is ORed into the core's SFR read mux.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit, minimum 2; counter width is $clog2(CLKS_PER_BIT).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- data_in  input  8  SFR write data
- addr  input  8  SFR direct address for byte access, or bit address for bit access
- wr_en  input  1  write strobe
- wr_bit_en  input  1  qualifies wr_en as a bit write
- bit_in  input  1  bit-write value
- rd_data  output  8  SCON when addr==SFR_SCON, SBUF shadow when addr==SFR_SBUF, else 8'h00; combinational
- txd  output  1  serial out, idle high
- busy  output  1  frame in progress
- int_req  output  1  SCON.TI | SCON.RI

Behaviour:
- Reset (synchronous, active-high; only one clock, no asynchronous paths):
  - scon = 8'h00, sbuf shadow = 8'h00, shift register = 8'h00, bit counter = 0, baud counter = 0.
  - FSM goes to IDLE; txd=1, busy=0, int_req=0.
  - Reset asserted mid-frame aborts the frame: txd=1 on the next edge and TI is not set.
- Decodes:
  - wr_sbuf = wr_en & !wr_bit_en & addr==SFR_SBUF.
  - wr_scon = wr_en & !wr_bit_en & addr==SFR_SCON.
  - wr_scon_b = wr_en & wr_bit_en & addr[7:3]==SFR_SCON[7:3]; it writes scon[addr[2:0]] = bit_in.
- Mode: SM0/SM1 are stored only. All frames use mode-1 timing regardless of their value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. On wr_sbuf (edge N): load the shift register and sbuf shadow with data_in, clear the baud counter, enter START. From edge N, busy=1 and txd=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then enter DATA with bit counter 0.
  - DATA: txd = shift[0]; shift right every CLKS_PER_BIT cycles. After bit 7 completes, enter STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then enter IDLE and busy=0.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- TI: set on the edge that enters STOP, so it is visible during the first stop-bit cycle. Software clears it by byte or bit write.
- Boundary conditions:
  - Simultaneous hardware TI set and software write of TI in the same cycle: the hardware set wins (TI=1). The other SCON bits take the written value.
  - wr_sbuf while busy (START/DATA/STOP): ignored entirely. Shift register, shadow and timing are unchanged; no error flag.
  - wr_sbuf on the same edge STOP returns to IDLE: ignored; software must observe busy=0 first.
  - Bit write to any SCON bit, including TI and RI, behaves as a normal register write. Software may set TI to force int_req.
  - RI (scon[0]) is storage only in this block.
- rd_data has no latency. Reads have no side effects.

Decomposition:
- Add SFR_SBUF (8'h99) and SFR_SCON (8'h98) to define_opcodes.v alongside the existing SFR addresses.
- Add SCON bit index constants SCON_TI=1, SCON_RI=0 and the state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3) to the same shared defines file.
- One natural sub-module: uart_baud_gen. It holds the CLKS_PER_BIT counter, with inputs clear and enable and output bit_tick, pulsing on the last cycle of each bit.
- The FSM and SFR registers stay in sfr_uart_tx.

Test Plan:
- Reset, then write SBUF=8'hA5 at edge 0 with CLKS_PER_BIT=4 -> txd low edges 0-3; data bits 1,0,1,0,0,1,0,1 in 4-cycle slots; txd high from edge 36; TI=1 from edge 36; busy=0 from edge 40.
- Write SBUF=8'h3C at edge 10 while a frame is in progress -> txd waveform, busy and rd_data at SFR_SBUF all unchanged (still 8'hA5).
- Bit write addr=8'h99 (SCON.1) bit_in=0 on the exact edge TI is set by hardware -> TI=1, int_req=1. A repeat of the bit write one cycle later -> TI=0, int_req=0.
- Byte write SCON=8'h41, then bit write addr=8'h9F bit_in=1 -> rd_data at addr 8'h98 reads 8'hC1, int_req=1 (RI). Read at addr 8'h50 returns 8'h00.
- Assert reset for 1 cycle at edge 20 of a frame -> on the next edge txd=1, busy=0, scon=8'h00. A subsequent SBUF write starts a clean frame.
- Write SBUF on the edge the FSM returns from STOP to IDLE -> write ignored, no frame. The same write one cycle later -> frame starts normally.
